stamp_write_arbiter: RTL

Multi-requester scheduler that shares the profiling counter's single global-memory write path between `NUM_CH` command channels. Each channel delivers commands tagged with a captured 64-bit timestamp. The block buffers one command per channel and grants channels round-robin. It emits one write record per stamp command, at consecutive 8-byte slots from a host-supplied base offset, and signals completion once every channel has sent its stop command and all records have drained.

---
 rtl/stamp_write_arbiter_pkg.sv | 25 ++
 rtl/stamp_write_arbiter_if.sv | 44 ++++
 rtl/stamp_write_arbiter_rr_arbiter.sv | 39 +++
 rtl/stamp_write_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/stamp_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prof_arb_pkg
//  Description : Shared command codes, record geometry and FSM state
//                encoding for the profiling-counter write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package prof_arb_pkg;

    // Channel command codes
    localparam logic [3:0] CMD_STAMP = 4'h1;
    localparam logic [3:0] CMD_STOP  = 4'h2;

    // Every record occupies one 64-bit slot in the host buffer
    localparam int RECORD_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stamp_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : stamp_write_arbiter_if
//  Description : Control, per-channel request and write-record signals of
//                the stamp write arbiter. The slave modport is the arbiter,
//                the master modport is the host/channel side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stamp_write_arbiter_if #(
    parameter int NUM_CH      = 4,
    parameter int MAX_RECORDS = 1024
) ();
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_RECORDS + 1);

    logic                   start;
    logic [63:0]            offset;
    logic [NUM_CH-1:0]      req_valid;
    logic [NUM_CH-1:0]      req_ready;
    logic [4*NUM_CH-1:0]    req_cmd;
    logic [64*NUM_CH-1:0]   req_value;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [63:0]            wr_addr;
    logic [63:0]            wr_data;
    logic [CH_W-1:0]        wr_ch;
    logic [CNT_W-1:0]       rec_count;
    logic                   overflow;
    logic                   done;

    modport slave (
        input  start, offset, req_valid, req_cmd, req_value, wr_ready,
        output req_ready, wr_valid, wr_addr, wr_data, wr_ch,
               rec_count, overflow, done
    );

    modport master (
        output start, offset, req_valid, req_cmd, req_value, wr_ready,
        input  req_ready, wr_valid, wr_addr, wr_data, wr_ch,
               rec_count, overflow, done
    );

endinterface
`default_nettype wire

// File: rtl/stamp_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Scans the request vector
//                starting one past the last-granted index and returns the
//                first hit as a one-hot grant plus its binary index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0]   i_req,
    input  logic [CH_W-1:0]     i_ptr,
    output logic [NUM_CH-1:0]   o_grant,
    output logic [CH_W-1:0]     o_idx,
    output logic                o_any
);
    int w_j;

    // First requester at or after ptr+1 (wrapping) wins; the last-granted
    // index is visited last, which bounds every waiter to NUM_CH grants
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_CH;
            if (!o_any && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = CH_W'(w_j);
                o_any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stamp_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stamp_write_arbiter
//  Description : Shares the single global-memory write path between NUM_CH
//                stamp channels. One command slot per channel, round-robin
//                grant into a one-deep output register, consecutive 8-byte
//                record slots from the host offset, done after all channels
//                have stopped and every record has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module stamp_write_arbiter
    import prof_arb_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MAX_RECORDS = 1024
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    stamp_write_arbiter_if.slave    bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_RECORDS + 1);
    localparam int IDX_W = CNT_W + 1;

    state_t             r_state;
    logic [63:0]        r_offset;
    logic [NUM_CH-1:0]  r_pend;
    logic [NUM_CH-1:0]  r_stop;
    logic [63:0]        r_slot_val [NUM_CH];
    logic [CH_W-1:0]    r_ptr;
    logic               r_wr_valid;
    logic [63:0]        r_wr_addr;
    logic [63:0]        r_wr_data;
    logic [CH_W-1:0]    r_wr_ch;
    logic [CNT_W-1:0]   r_rec_count;
    logic               r_overflow;
    logic               r_done;

    logic [NUM_CH-1:0]  w_req_ready;
    logic [NUM_CH-1:0]  w_hs;
    logic [NUM_CH-1:0]  w_grant;
    logic [CH_W-1:0]    w_grant_idx;
    logic               w_grant_any;
    logic               w_wr_hs;
    logic               w_grant_en;
    logic               w_emit;
    logic [IDX_W-1:0]   w_next_idx;
    logic [63:0]        w_rec_addr;

    // A slot accepts only while empty, so a stop can never overtake a stamp
    assign w_req_ready = (r_state == ST_RUN) ? (~r_pend & ~r_stop) : '0;
    assign w_hs        = bus.req_valid & w_req_ready;
    assign w_wr_hs     = r_wr_valid && bus.wr_ready;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .i_req   (r_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // Grant only into an empty or draining output register
    assign w_grant_en = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) &&
                        (!r_wr_valid || bus.wr_ready) && w_grant_any;

    // Next record index counts the record still sitting in the output
    // register; when that record is consumed this cycle the sum equals the
    // post-edge rec_count, so the index is correct in both cases
    assign w_next_idx = IDX_W'(r_rec_count) + IDX_W'(r_wr_valid);
    assign w_emit     = w_grant_en && (w_next_idx < IDX_W'(MAX_RECORDS));
    assign w_rec_addr = r_offset + 64'(w_next_idx) * 64'(RECORD_BYTES);

    assign bus.req_ready = w_req_ready;
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_ch     = r_wr_ch;
    assign bus.rec_count = r_rec_count;
    assign bus.overflow  = r_overflow;
    assign bus.done      = r_done;

    // Run FSM, channel slots, stop mask and the output record register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= ST_IDLE;
            r_offset    <= '0;
            r_pend      <= '0;
            r_stop      <= '0;
            r_ptr       <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_ch     <= '0;
            r_rec_count <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_slot_val[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;

            if (w_wr_hs) begin
                r_wr_valid  <= 1'b0;
                r_rec_count <= r_rec_count + CNT_W'(1);
            end

            // Granted stamp leaves its slot; past capacity it is dropped
            if (w_grant_en) begin
                r_ptr <= w_grant_idx;
                if (w_emit) begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= w_rec_addr;
                    r_wr_data  <= r_slot_val[w_grant_idx];
                    r_wr_ch    <= w_grant_idx;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            // Accepted commands fill empty slots; unknown commands vanish
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hs[i]) begin
                    if (bus.req_cmd[4*i +: 4] == CMD_STAMP) begin
                        r_pend[i]     <= 1'b1;
                        r_slot_val[i] <= bus.req_value[64*i +: 64];
                    end else if (bus.req_cmd[4*i +: 4] == CMD_STOP) begin
                        r_stop[i] <= 1'b1;
                    end
                end else if (w_grant_en && w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_RUN;
                        r_offset    <= bus.offset;
                        r_pend      <= '0;
                        r_stop      <= '0;
                        r_ptr       <= '0;
                        r_rec_count <= '0;
                        r_overflow  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (&r_stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((r_pend == '0) && !r_wr_valid) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
